// File: rtl/apx_error_monitor.sv
// Error-metric collector for an approximate multiplier: accumulates ED statistics over a
// window of N_SAMPLES (approx, exact) product pairs, then divides the ED sum to get the mean.
module apx_error_monitor #(
   parameter int unsigned P_W       = 8,
   parameter int unsigned N_SAMPLES = 256,
   parameter int unsigned CNT_W     = $clog2(N_SAMPLES + 1),
   parameter int unsigned SUM_W     = P_W + $clog2(N_SAMPLES),
   parameter int unsigned FRAC      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [P_W-1:0]          approx_p_i,
   input  logic [P_W-1:0]          exact_p_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CNT_W-1:0]        err_count_o,
   output logic [P_W-1:0]          max_ed_o,
   output logic [SUM_W-1:0]        sum_ed_o,
   output logic [SUM_W+FRAC-1:0]   mean_ed_o
);

   localparam int unsigned Q_W    = SUM_W + FRAC;
   localparam int unsigned STEP_W = $clog2(Q_W);
   // Remainder stays below N_SAMPLES; one extra bit absorbs the shift before the subtract.
   localparam int unsigned R_W    = CNT_W + 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccum  = 2'd1;
   localparam logic [1:0] StDivide = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [P_W-1:0]    max_q, max_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [Q_W-1:0]    mean_q, mean_d;
   logic [Q_W-1:0]    dvd_q, dvd_d;
   logic [Q_W-1:0]    quo_q, quo_d;
   logic [R_W-1:0]    rem_q, rem_d;
   logic [STEP_W-1:0] step_q, step_d;

   logic              accept;
   logic [P_W-1:0]    ed;
   logic [R_W-1:0]    rem_shift;
   logic              rem_ge;
   logic [R_W-1:0]    rem_next;
   logic [Q_W-1:0]    quo_next;

   assign accept    = (state_q == StAccum) && in_valid_i;
   assign ed        = (approx_p_i >= exact_p_i) ? (approx_p_i - exact_p_i)
                                                : (exact_p_i - approx_p_i);

   // One restoring-division step: bring in the next dividend bit MSB first.
   assign rem_shift = {rem_q[R_W-2:0], dvd_q[Q_W-1]};
   assign rem_ge    = (rem_shift >= R_W'(N_SAMPLES));
   assign rem_next  = rem_ge ? (rem_shift - R_W'(N_SAMPLES)) : rem_shift;
   assign quo_next  = {quo_q[Q_W-2:0], rem_ge};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      max_d   = max_q;
      sum_d   = sum_q;
      mean_d  = mean_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      step_d  = step_q;

      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StAccum;
               cnt_d   = '0;
               err_d   = '0;
               max_d   = '0;
               sum_d   = '0;
               mean_d  = '0;
            end
         end

         StAccum: begin
            if (accept) begin
               sum_d = sum_q + SUM_W'(ed);
               cnt_d = cnt_q + CNT_W'(1);
               if (ed > max_q) begin
                  max_d = ed;
               end
               if (ed != '0) begin
                  err_d = err_q + CNT_W'(1);
               end
               if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                  state_d = StDivide;
                  dvd_d   = {sum_d, {FRAC{1'b0}}};
                  quo_d   = '0;
                  rem_d   = '0;
                  step_d  = '0;
               end
            end
         end

         StDivide: begin
            dvd_d  = {dvd_q[Q_W-2:0], 1'b0};
            rem_d  = rem_next;
            quo_d  = quo_next;
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(Q_W - 1)) begin
               state_d = StDone;
               mean_d  = quo_next;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= '0;
         max_q   <= '0;
         sum_q   <= '0;
         mean_q  <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         mean_q  <= mean_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         step_q  <= step_d;
      end
   end

   assign in_ready_o  = (state_q == StAccum);
   assign busy_o      = (state_q == StAccum) || (state_q == StDivide);
   assign done_o      = (state_q == StDone);
   assign err_count_o = err_q;
   assign max_ed_o    = max_q;
   assign sum_ed_o    = sum_q;
   assign mean_ed_o   = mean_q;

endmodule

// File: tb/tb_apx_error_monitor.sv
// Directed bench for apx_error_monitor: a default 256-sample instance and a 4-sample instance.
module tb_apx_error_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Default instance (N_SAMPLES = 256).
   logic        a_start, a_valid, a_ready, a_busy, a_done;
   logic [7:0]  a_approx, a_exact, a_max;
   logic [8:0]  a_err;
   logic [15:0] a_sum;
   logic [23:0] a_mean;

   // Small instance (N_SAMPLES = 4).
   logic        b_start, b_valid, b_ready, b_busy, b_done;
   logic [7:0]  b_approx, b_exact, b_max;
   logic [2:0]  b_err;
   logic [9:0]  b_sum;
   logic [17:0] b_mean;

   int n_checks = 0;
   int n_pass   = 0;
   int cycles;

   apx_error_monitor u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .start_i     (a_start),
      .in_valid_i  (a_valid),
      .in_ready_o  (a_ready),
      .approx_p_i  (a_approx),
      .exact_p_i   (a_exact),
      .busy_o      (a_busy),
      .done_o      (a_done),
      .err_count_o (a_err),
      .max_ed_o    (a_max),
      .sum_ed_o    (a_sum),
      .mean_ed_o   (a_mean)
   );

   apx_error_monitor #(
      .N_SAMPLES (4)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .start_i     (b_start),
      .in_valid_i  (b_valid),
      .in_ready_o  (b_ready),
      .approx_p_i  (b_approx),
      .exact_p_i   (b_exact),
      .busy_o      (b_busy),
      .done_o      (b_done),
      .err_count_o (b_err),
      .max_ed_o    (b_max),
      .sum_ed_o    (b_sum),
      .mean_ed_o   (b_mean)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic a_pulse_start();
      @(negedge clk);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic a_pair(input logic [7:0] ap, input logic [7:0] ex);
      @(negedge clk);
      a_valid  = 1'b1;
      a_approx = ap;
      a_exact  = ex;
      @(posedge clk);
      #1 a_valid = 1'b0;
   endtask

   task automatic b_pair(input logic [7:0] ap, input logic [7:0] ex, input logic st);
      @(negedge clk);
      b_valid  = 1'b1;
      b_approx = ap;
      b_exact  = ex;
      b_start  = st;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic a_check_results(input string tag, input int err, input int mx, input int sum,
                                  input int mean);
      check({tag, "_err"},  32'(a_err),  err);
      check({tag, "_max"},  32'(a_max),  mx);
      check({tag, "_sum"},  32'(a_sum),  sum);
      check({tag, "_mean"}, 32'(a_mean), mean);
   endtask

   initial begin
      a_start = 0; a_valid = 0; a_approx = 0; a_exact = 0;
      b_start = 0; b_valid = 0; b_approx = 0; b_exact = 0;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy",  32'(a_busy),  0);
      check("rst_done",  32'(a_done),  0);
      check("rst_ready", 32'(a_ready), 0);
      a_check_results("rst", 0, 0, 0, 0);
      rst = 1'b0;

      // Window 1: exact multiplier sweep, zero error; extra pairs pushed during DIVIDE.
      a_pulse_start();
      check("w1_ready", 32'(a_ready), 1);
      check("w1_busy",  32'(a_busy),  1);
      for (int i = 0; i < 256; i++) begin
         a_pair(8'((i / 16) * (i % 16)), 8'((i / 16) * (i % 16)));
      end
      cycles = 0;
      @(negedge clk);
      a_valid  = 1'b1;
      a_approx = 8'hFF;
      a_exact  = 8'h00;
      check("w1_div_ready", 32'(a_ready), 0);
      check("w1_div_busy",  32'(a_busy),  1);
      check("w1_div_mean",  32'(a_mean),  0);
      while (!a_done && cycles < 100) begin
         @(posedge clk);
         #1 cycles++;
      end
      check("w1_latency", cycles, 24);
      repeat (3) @(negedge clk);
      a_valid = 1'b0;
      check("w1_done", 32'(a_done), 1);
      check("w1_busy_done", 32'(a_busy), 0);
      a_check_results("w1", 0, 0, 0, 0);

      // Window 2 aborted by reset after 100 pairs of ED |255-2i|.
      a_pulse_start();
      for (int i = 0; i < 100; i++) begin
         a_pair(8'(255 - i), 8'(i));
      end
      @(negedge clk);
      check("w2_partial_sum", 32'(a_sum), 15600);
      check("w2_partial_err", 32'(a_err), 100);
      rst = 1'b1;
      #1;
      check("w2_rst_ready", 32'(a_ready), 0);
      check("w2_rst_busy",  32'(a_busy),  0);
      a_check_results("w2_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Window 3: full sweep of ED |255-2i|, both subtraction directions, every pair in error.
      a_pulse_start();
      for (int i = 0; i < 256; i++) begin
         a_pair(8'(255 - i), 8'(i));
      end
      cycles = 0;
      while (!a_done && cycles < 100) begin
         @(posedge clk);
         #1 cycles++;
      end
      check("w3_latency", cycles, 24);
      a_check_results("w3", 256, 255, 32768, 32'h8000);

      // Restart from DONE clears results; window 4 has ED = i[0].
      a_pulse_start();
      check("w4_ready", 32'(a_ready), 1);
      check("w4_done",  32'(a_done),  0);
      a_check_results("w4_clr", 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) begin
         a_pair(8'(i & 8'hFE), 8'(i));
      end
      cycles = 0;
      while (!a_done && cycles < 100) begin
         @(posedge clk);
         #1 cycles++;
      end
      a_check_results("w4", 128, 1, 128, 32'h80);

      // Small window: start pulsed during ACCUM and DIVIDE must be ignored.
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      b_pair(8'd5,  8'd4,  1'b0);
      b_pair(8'd10, 8'd12, 1'b1);
      b_pair(8'd3,  8'd0,  1'b0);
      b_pair(8'd20, 8'd30, 1'b0);
      @(negedge clk);
      b_start = 1'b1;
      check("b1_div_mean", 32'(b_mean), 0);
      check("b1_div_busy", 32'(b_busy), 1);
      @(posedge clk);
      #1;
      cycles = 1;
      b_start = 1'b0;
      while (!b_done && cycles < 100) begin
         @(posedge clk);
         #1 cycles++;
      end
      check("b1_latency", cycles, 18);
      check("b1_err",  32'(b_err),  4);
      check("b1_max",  32'(b_max),  10);
      check("b1_sum",  32'(b_sum),  16);
      check("b1_mean", 32'(b_mean), 32'h400);

      // Gapped valid: idle cycles between pairs do not count.
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b2_clr_sum",  32'(b_sum),  0);
      check("b2_clr_mean", 32'(b_mean), 0);
      b_pair(8'd1, 8'd0, 1'b0);
      @(posedge clk);
      b_pair(8'd7, 8'd8, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("b2_mid_sum",  32'(b_sum),  2);
      check("b2_mid_busy", 32'(b_busy), 1);
      b_pair(8'd200, 8'd199, 1'b0);
      @(posedge clk);
      b_pair(8'd9, 8'd9, 1'b0);
      cycles = 0;
      while (!b_done && cycles < 100) begin
         @(posedge clk);
         #1 cycles++;
      end
      check("b2_latency", cycles, 18);
      check("b2_err",  32'(b_err),  3);
      check("b2_max",  32'(b_max),  1);
      check("b2_sum",  32'(b_sum),  3);
      check("b2_mean", 32'(b_mean), 32'hC0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/apx_error_monitor.md
Name: apx_error_monitor

Overview:
- Hardware error-metric collector placed directly downstream of approximate_multiplier_4x4.
- Consumes a stream of (approximate product, exact product) pairs and accumulates error statistics over a programmed window of N_SAMPLES pairs.
- Reports error count, maximum error distance (ED), ED sum and mean ED (fixed point), so multiplier characterisation runs in RTL or on FPGA without a software model.

Parameters:
- P_W, 8: product width, matching the 4x4 multiplier output.
- N_SAMPLES, 256: pairs per measurement window, >= 1 (256 = exhaustive 4x4 sweep).
- CNT_W, $clog2(N_SAMPLES+1): sample/error counter width.
- SUM_W, P_W+$clog2(N_SAMPLES): ED accumulator width, sized so it never overflows.
- FRAC, 8: fractional bits of mean_ed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new window; honoured only in IDLE or DONE.
- in_valid  in  1  approx_p/exact_p valid.
- in_ready  out  1  monitor accepts a pair this cycle.
- approx_p  in  P_W  approximate product.
- exact_p  in  P_W  exact product.
- busy  out  1  high in ACCUM or DIVIDE.
- done  out  1  high in DONE; results valid and stable.
- err_count  out  CNT_W  pairs with approx_p != exact_p.
- max_ed  out  P_W  largest |approx_p - exact_p| in window.
- sum_ed  out  SUM_W  sum of |approx_p - exact_p|.
- mean_ed  out  SUM_W+FRAC  floor(sum_ed * 2^FRAC / N_SAMPLES), unsigned fixed point.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs, counters, accumulators and divider registers = 0.
- FSM states: IDLE, ACCUM, DIVIDE, DONE.
- IDLE/DONE + start=1: clear err_count, max_ed, sum_ed, mean_ed and sample counter; next state ACCUM.
- start=0: IDLE and DONE hold.
- start in ACCUM or DIVIDE: ignored.
- ACCUM:
  - in_ready=1 (combinational from state only). It is not dependent on in_valid.
  - A pair is accepted on a cycle with in_valid && in_ready. Gaps in in_valid are allowed and do not advance the counter.
  - Per accepted pair: ed = |approx_p - exact_p|, computed unsigned in P_W bits without wrap.
  - sum_ed += ed; max_ed = max(max_ed, ed); err_count += (ed != 0); sample counter += 1.
  - Registers update on the accepting edge; no pipeline delay.
- Transition to DIVIDE: on the edge that accepts pair number N_SAMPLES. in_ready=0 from the next cycle; later pairs are not consumed.
- DIVIDE:
  - Sequential restoring division of {sum_ed, FRAC zeros} by N_SAMPLES, one quotient bit per cycle, MSB first.
  - Runs exactly SUM_W+FRAC cycles, then enters DONE.
  - mean_ed is written only on entry to DONE; it reads 0 during DIVIDE.
- Latency: if the last pair is accepted at edge t, DIVIDE is entered at t, and done rises at edge t+SUM_W+FRAC (24 cycles at defaults).
- DONE: all results hold until start or rst.
- Degenerate windows: exact_p=0 pairs are counted normally. ed = approx_p, and no special case applies.
- N_SAMPLES=1: DIVIDE still runs the full cycle count, and mean_ed = sum_ed << FRAC.

Test Plan:
- Reset, then start; feed 256 pairs with approx_p=exact_p=A*B -> err_count=0, max_ed=0, sum_ed=0, mean_ed=0, done 24 cycles after the last accept.
- N_SAMPLES=4; pairs (5,4),(10,12),(3,0),(20,30) -> ed 1,2,3,10; sum_ed=16, max_ed=10, err_count=4, mean_ed=0x000400.
- N_SAMPLES=4; ed 1,1,1,0 with in_valid low on alternate cycles -> only valid cycles counted; sum_ed=3, err_count=3, mean_ed=0x0000C0.
- Assert start during ACCUM and DIVIDE -> no effect, results as if start were never pulsed. After DONE, start -> outputs cleared, ACCUM re-entered.
- rst pulse mid-ACCUM after 100 pairs -> immediate IDLE, all outputs 0, in_ready=0. A new start gives a clean full-window result.
- After pair N_SAMPLES, hold in_valid=1 -> in_ready=0, and extra pairs do not change sum_ed, max_ed or err_count.
